// File: rtl/servo_link_pkg.sv
// Shared definitions for the servo link arbiter: link FSM states, command field widths,
// the default ms divider and a helper that sizes the ms counter.
package servo_link_pkg;

    localparam int ID_W            = 8;
    localparam int LOC_W           = 16;
    localparam int DEFAULT_CLK_DIV = 50_000;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_FIN,
        GAP
    } link_state_e;

    // Width of an ms counter that can reach the larger of the two delays without wrapping.
    function automatic int ms_count_width(input int gap_ms, input int timeout_ms);
        int max_ms = (gap_ms > timeout_ms) ? gap_ms : timeout_ms;
        return (max_ms > 0) ? $clog2(max_ms + 1) : 1;
    endfunction

endpackage

// File: rtl/servo_link_arbiter_ms_tick_timer.sv
// Millisecond timebase: a 0..CLK_DIV-1 divider whose wrap is the tick, plus a
// saturating count of ticks since the last clear.
module ms_tick_timer
    import servo_link_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV,
    parameter int MS_W    = 8
) (
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    input  logic            clr,
    input  logic            en,
    output logic            tick,
    output logic [MS_W-1:0] ms_count
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [MS_W-1:0]  MS_MAX   = '1;

    logic [DIV_W-1:0] div_cnt;

    assign tick = en && (div_cnt == DIV_LAST);

    // NOTE: reset is sampled on the clock edge and, like all state here, updated with <= only.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || clr) begin
            div_cnt  <= '0;
            ms_count <= '0;
        end else if (en) begin
            if (tick) begin
                div_cnt <= '0;
                if (ms_count != MS_MAX)
                    ms_count <= ms_count + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/servo_link_arbiter.sv
// Round-robin arbiter that hands one servo command at a time to a single UART sender,
// waits for its finish (or a timeout) and then holds the link idle for a minimum gap.
module servo_link_arbiter
    import servo_link_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  CLK_DIV    = DEFAULT_CLK_DIV,
    parameter int  GAP_MS     = 20,
    parameter int  TIMEOUT_MS = 100,
    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [ID_W*NUM_REQ-1:0]  req_id,
    input  logic [LOC_W*NUM_REQ-1:0] req_location,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       req_done,
    output logic [NUM_REQ-1:0]       req_err,
    output logic                     n2c_en,
    output logic [ID_W-1:0]          ID,
    output logic [LOC_W-1:0]         location,
    input  logic                     finish,
    output logic                     busy,
    output logic [IDX_W-1:0]         grant_idx
);

    localparam int              MS_W     = ms_count_width(GAP_MS, TIMEOUT_MS);
    localparam logic [MS_W-1:0] GAP_LAST = MS_W'((GAP_MS > 0) ? GAP_MS - 1 : 0);
    localparam logic [MS_W-1:0] TO_LAST  = MS_W'((TIMEOUT_MS > 0) ? TIMEOUT_MS - 1 : 0);

    link_state_e        state;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   grant_sel;
    logic               grant_hit;
    logic [NUM_REQ-1:0] owner_bit;
    logic [ID_W-1:0]    id_arr  [NUM_REQ];
    logic [LOC_W-1:0]   loc_arr [NUM_REQ];

    logic               timer_clr;
    logic               timer_en;
    logic               ms_tick;
    logic [MS_W-1:0]    ms_count;
    logic               timeout_hit;
    logic               gap_done;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign id_arr[k]  = req_id[ID_W*k +: ID_W];
        assign loc_arr[k] = req_location[LOC_W*k +: LOC_W];
    end

    // Walk from the farthest candidate to the nearest so the requester right after
    // last_grant overwrites everything else.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        grant_hit = 1'b0;
        grant_sel = last_grant;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_valid[IDX_W'((int'(last_grant) + i) % NUM_REQ)]) begin
                grant_hit = 1'b1;
                grant_sel = IDX_W'((int'(last_grant) + i) % NUM_REQ);
            end
        end
    end

    // The accept is same-cycle so a requester that drops valid can never be granted.
    assign req_ready = (state == IDLE && sys_rst_n && grant_hit) ?
                       (NUM_REQ'(1) << grant_sel) : '0;
    assign owner_bit = NUM_REQ'(1) << last_grant;

    assign timeout_hit = (TIMEOUT_MS == 0) || (ms_tick && ms_count == TO_LAST);
    assign gap_done    = (GAP_MS == 0) || (ms_tick && ms_count == GAP_LAST);
    assign timer_en    = (state == WAIT_FIN) || (state == GAP);
    assign timer_clr   = (state == SEND) ||
                         (state == WAIT_FIN && (finish || timeout_hit));

    ms_tick_timer #(
        .CLK_DIV (CLK_DIV),
        .MS_W    (MS_W)
    ) u_ms_tick_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (timer_clr),
        .en        (timer_en),
        .tick      (ms_tick),
        .ms_count  (ms_count)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            n2c_en     <= 1'b0;
            req_done   <= '0;
            req_err    <= '0;
            busy       <= 1'b0;
            ID         <= '0;
            location   <= '0;
            grant_idx  <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else begin
            n2c_en   <= 1'b0;
            req_done <= '0;
            req_err  <= '0;
            case (state)
                IDLE: begin
                    if (grant_hit) begin
                        state      <= SEND;
                        n2c_en     <= 1'b1;
                        busy       <= 1'b1;
                        ID         <= id_arr[grant_sel];
                        location   <= loc_arr[grant_sel];
                        last_grant <= grant_sel;
                        grant_idx  <= grant_sel;
                    end
                end
                SEND: state <= WAIT_FIN;
                WAIT_FIN: begin
                    // A finish coinciding with the timeout tick still counts as success.
                    if (finish) begin
                        req_done <= owner_bit;
                        state    <= GAP;
                    end else if (timeout_hit) begin
                        req_err <= owner_bit;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_link_arbiter.sv
// Self-checking bench for servo_link_arbiter: scenario tasks plus randomized commands
// checked against a cycle-count model of arbitration, timeout and gap rules.
module tb_servo_link_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int CLK_DIV    = 10;
    localparam int GAP_MS     = 2;
    localparam int TIMEOUT_MS = 5;
    localparam int WAIT_CYC   = TIMEOUT_MS * CLK_DIV;
    localparam int GAP_CYC    = GAP_MS * CLK_DIV;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_id;
    logic [63:0] req_location;
    logic [3:0]  req_ready;
    logic [3:0]  req_done;
    logic [3:0]  req_err;
    logic        n2c_en;
    logic [7:0]  ID;
    logic [15:0] location;
    logic        finish;
    logic        busy;
    logic [1:0]  grant_idx;

    int          checks = 0;
    int          errors = 0;
    int          model_last;
    logic [7:0]  model_id;
    logic [15:0] model_loc;

    servo_link_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .CLK_DIV    (CLK_DIV),
        .GAP_MS     (GAP_MS),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .req_valid    (req_valid),
        .req_id       (req_id),
        .req_location (req_location),
        .req_ready    (req_ready),
        .req_done     (req_done),
        .req_err      (req_err),
        .n2c_en       (n2c_en),
        .ID           (ID),
        .location     (location),
        .finish       (finish),
        .busy         (busy),
        .grant_idx    (grant_idx)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Round-robin rule: first valid requester after the last winner, wrapping around.
    function automatic int rr_pick(input int last, input logic [3:0] mask);
        for (int i = 1; i <= NUM_REQ; i++)
            if (mask[(last + i) % NUM_REQ]) return (last + i) % NUM_REQ;
        return -1;
    endfunction

    task automatic do_cmd(input logic [3:0] mask, input logic [31:0] ids, input logic [63:0] locs,
                          input int fin, input bit hold, input logic [3:0] poke, input int poke_c,
                          output int obs);
        int         w;
        int         endc;
        bit         fin_ok;
        bit         got;
        logic [3:0] exp_bit;
        logic [3:0] exp_done;
        logic [3:0] exp_err;
        w       = rr_pick(model_last, mask);
        exp_bit = 4'b0001 << w;
        obs     = -1;
        @(posedge sys_clk); #1;
        req_valid = mask; req_id = ids; req_location = locs; finish = 1'b0;
        @(negedge sys_clk);
        got = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (req_ready != 4'b0) begin got = 1'b1; break; end
            @(posedge sys_clk); #1; @(negedge sys_clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL grant_wait: got no req_ready within 200 cycles, expected %b", exp_bit);
            return;
        end
        checks++;
        if (req_ready !== exp_bit || busy !== 1'b0) begin
            errors++;
            $display("FAIL grant: got ready=%b busy=%b expected ready=%b busy=0", req_ready, busy, exp_bit);
        end
        model_last = w;
        model_id   = ids[8*w +: 8];
        model_loc  = locs[16*w +: 16];
        fin_ok     = (fin >= 1) && (fin <= WAIT_CYC);
        endc       = fin_ok ? fin : WAIT_CYC;
        for (int c = 0; c <= endc + GAP_CYC; c++) begin
            @(posedge sys_clk); #1;
            req_valid = (hold ? mask : 4'b0) | ((c == poke_c) ? poke : 4'b0);
            finish    = (c == fin);
            @(negedge sys_clk);
            if (c == 0) obs = int'(grant_idx);
            exp_done = (fin_ok && c == endc + 1) ? exp_bit : 4'b0;
            exp_err  = (!fin_ok && c == endc + 1) ? exp_bit : 4'b0;
            checks++;
            if (n2c_en !== (c == 0)) begin
                errors++;
                $display("FAIL n2c_en c=%0d: got %b expected %b", c, n2c_en, (c == 0));
            end
            checks++;
            if (req_done !== exp_done || req_err !== exp_err) begin
                errors++;
                $display("FAIL done_err c=%0d: got done=%b err=%b expected done=%b err=%b",
                         c, req_done, req_err, exp_done, exp_err);
            end
            checks++;
            if (req_ready !== 4'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_ready c=%0d: got ready=%b busy=%b expected ready=0000 busy=1",
                         c, req_ready, busy);
            end
            checks++;
            if (ID !== model_id || location !== model_loc || grant_idx !== 2'(w)) begin
                errors++;
                $display("FAIL latch c=%0d: got ID=%h loc=%h idx=%0d expected ID=%h loc=%h idx=%0d",
                         c, ID, location, grant_idx, model_id, model_loc, w);
            end
        end
        finish = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0; req_valid = 4'hF; req_id = $urandom;
        req_location = {$urandom, $urandom}; finish = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if ({n2c_en, busy, req_ready, req_done, req_err} !== 11'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got n2c=%b busy=%b ready=%b done=%b err=%b expected all 0",
                     n2c_en, busy, req_ready, req_done, req_err);
        end
        checks++;
        if (ID !== 8'h00 || location !== 16'h0000 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_data: got ID=%h loc=%h idx=%0d expected 00 0000 0", ID, location, grant_idx);
        end
        model_last = NUM_REQ - 1; model_id = '0; model_loc = '0;
        sys_rst_n = 1'b1; req_valid = 4'b0; finish = 1'b0;
    endtask

    task automatic test_round_robin();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        int obs;
        for (int i = 0; i < 5; i++) begin
            do_cmd(4'hF, $urandom, {$urandom, $urandom}, 2, 1'b1, 4'b0, -1, obs);
            checks++;
            if (obs !== exp_seq[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", i, obs, exp_seq[i]);
            end
        end
    endtask

    task automatic test_single();
        int obs;
        do_cmd(4'b0100, 32'h0003_0000, 64'h0000_01F4_0000_0000, 30, 1'b0, 4'b0, -1, obs);
        checks++;
        if (obs !== 2 || model_id !== 8'h03 || model_loc !== 16'h01F4) begin
            errors++;
            $display("FAIL single: got idx=%0d expected 2", obs);
        end
    endtask

    task automatic test_timeout();
        int obs;
        do_cmd(4'b0010, $urandom, {$urandom, $urandom}, -1, 1'b0, 4'b0, -1, obs);
        // finish during SEND must be ignored, so this one also times out
        do_cmd(4'b1001, $urandom, {$urandom, $urandom}, 0, 1'b0, 4'b0, -1, obs);
    endtask

    task automatic test_simultaneous();
        int obs;
        do_cmd(4'b1000, $urandom, {$urandom, $urandom}, WAIT_CYC, 1'b0, 4'b0, -1, obs);
    endtask

    task automatic test_idle_finish();
        @(posedge sys_clk); #1;
        req_valid = 4'b0; finish = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            checks++;
            if ({n2c_en, busy, req_ready, req_done, req_err} !== 11'b0 ||
                ID !== model_id || location !== model_loc) begin
                errors++;
                $display("FAIL idle_finish c=%0d: got n2c=%b busy=%b done=%b err=%b ID=%h loc=%h expected quiet ID=%h loc=%h",
                         c, n2c_en, busy, req_done, req_err, ID, location, model_id, model_loc);
            end
            @(posedge sys_clk); #1;
            finish = 1'b0;
        end
    endtask

    task automatic test_withdrawn();
        int obs;
        do_cmd(4'b0001, $urandom, {$urandom, $urandom}, 10, 1'b0, 4'b1000, 15, obs);
        for (int c = 0; c < 30; c++) begin
            @(posedge sys_clk); #1;
            req_valid = 4'b0;
            @(negedge sys_clk);
            checks++;
            if (n2c_en !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL withdrawn c=%0d: got n2c=%b ready=%b busy=%b expected 0 0000 0",
                         c, n2c_en, req_ready, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit got;
        int obs;
        @(posedge sys_clk); #1;
        req_valid = 4'b0100; req_id = $urandom; req_location = {$urandom, $urandom};
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge sys_clk);
            if (req_ready != 4'b0) begin got = 1'b1; break; end
            @(posedge sys_clk); #1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL reset_mid_grant: got no req_ready, expected 0100");
        end
        @(posedge sys_clk); #1;
        req_valid = 4'b0;
        repeat (10) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b0; req_valid = 4'hF;
        @(posedge sys_clk); #1;
        checks++;
        if ({n2c_en, busy, req_ready, req_done, req_err} !== 11'b0 ||
            ID !== 8'h00 || location !== 16'h0000 || grant_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid: got n2c=%b busy=%b ready=%b done=%b err=%b ID=%h loc=%h idx=%0d expected all 0",
                     n2c_en, busy, req_ready, req_done, req_err, ID, location, grant_idx);
        end
        sys_rst_n = 1'b1; req_valid = 4'b0;
        model_last = NUM_REQ - 1; model_id = '0; model_loc = '0;
        do_cmd(4'hF, $urandom, {$urandom, $urandom}, 4, 1'b0, 4'b0, -1, obs);
        checks++;
        if (obs !== 0) begin
            errors++;
            $display("FAIL reset_mid_next: got idx=%0d expected 0", obs);
        end
    endtask

    task automatic test_random();
        int obs;
        int fin;
        for (int i = 0; i < 10; i++) begin
            fin = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 65));
            do_cmd(4'($urandom_range(1, 15)), $urandom, {$urandom, $urandom}, fin,
                   1'($urandom_range(0, 1)), 4'b0, -1, obs);
        end
    endtask

    initial begin
        req_valid = 4'b0; req_id = '0; req_location = '0; finish = 1'b0; sys_rst_n = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_simultaneous();
        test_idle_finish();
        test_withdrawn();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
